// File: rtl/timer_pkg.sv
// Shared op-codes, BCD digit limits and field layout for the multi-channel
// hh:mm:ss timer engine.
package timer_pkg;

  localparam logic [2:0] OP_NOP        = 3'd0;
  localparam logic [2:0] OP_START_STOP = 3'd1;
  localparam logic [2:0] OP_CLEAR      = 3'd2;
  localparam logic [2:0] OP_SELECT     = 3'd3;
  localparam logic [2:0] OP_MODE       = 3'd4;
  localparam logic [2:0] OP_LOAD       = 3'd5;

  localparam logic [3:0] UNIT_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX = 4'd5;
  localparam logic [7:0] HOUR_MAX = 8'h23;

  localparam int S1_LSB  = 0;
  localparam int S10_LSB = 4;
  localparam int M1_LSB  = 8;
  localparam int M10_LSB = 12;
  localparam int H1_LSB  = 16;
  localparam int H10_LSB = 20;

  localparam int ALARM_W = 32;

  // Byte compare on {h10,h1} is a valid BCD bound once h1 is known to be <= 9.
  function automatic logic bcd_valid(input logic [23:0] v);
    logic [3:0] h10;
    logic [3:0] h1;
    h10 = v[H10_LSB +: 4];
    h1  = v[H1_LSB +: 4];
    return (v[S1_LSB +: 4] <= UNIT_MAX) && (v[S10_LSB +: 4] <= TENS_MAX) &&
           (v[M1_LSB +: 4] <= UNIT_MAX) && (v[M10_LSB +: 4] <= TENS_MAX) &&
           (h1 <= UNIT_MAX) && ({h10, h1} <= HOUR_MAX);
  endfunction

endpackage

// File: rtl/bcd_hms_counter.sv
// One timer channel: BCD hh:mm:ss register with clear/load/increment/decrement.
// Priority is clear > load > step; decrement is never issued at 00:00:00.
module bcd_hms_counter
  import timer_pkg::*;
(
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic        inc,
  input  logic        dec,
  input  logic        clear,
  input  logic        load,
  input  logic [23:0] load_value,
  output logic [23:0] value,
  output logic        is_zero
);

  function automatic logic [23:0] bcd_up(input logic [23:0] v);
    logic [3:0] s1, s10, m1, m10, h1, h10;
    {h10, h1, m10, m1, s10, s1} = v;
    if (s1 != UNIT_MAX) s1 = s1 + 4'd1;
    else begin
      s1 = 4'd0;
      if (s10 != TENS_MAX) s10 = s10 + 4'd1;
      else begin
        s10 = 4'd0;
        if (m1 != UNIT_MAX) m1 = m1 + 4'd1;
        else begin
          m1 = 4'd0;
          if (m10 != TENS_MAX) m10 = m10 + 4'd1;
          else begin
            m10 = 4'd0;
            if ({h10, h1} == HOUR_MAX) begin
              h10 = 4'd0;
              h1  = 4'd0;
            end else if (h1 == UNIT_MAX) begin
              h1  = 4'd0;
              h10 = h10 + 4'd1;
            end else h1 = h1 + 4'd1;
          end
        end
      end
    end
    return {h10, h1, m10, m1, s10, s1};
  endfunction

  function automatic logic [23:0] bcd_down(input logic [23:0] v);
    logic [3:0] s1, s10, m1, m10, h1, h10;
    {h10, h1, m10, m1, s10, s1} = v;
    if (s1 != 4'd0) s1 = s1 - 4'd1;
    else begin
      s1 = UNIT_MAX;
      if (s10 != 4'd0) s10 = s10 - 4'd1;
      else begin
        s10 = TENS_MAX;
        if (m1 != 4'd0) m1 = m1 - 4'd1;
        else begin
          m1 = UNIT_MAX;
          if (m10 != 4'd0) m10 = m10 - 4'd1;
          else begin
            m10 = TENS_MAX;
            if (h1 != 4'd0) h1 = h1 - 4'd1;
            else if (h10 != 4'd0) begin
              h1  = UNIT_MAX;
              h10 = h10 - 4'd1;
            end else {h10, h1} = HOUR_MAX;
          end
        end
      end
    end
    return {h10, h1, m10, m1, s10, s1};
  endfunction

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset)     value <= '0;
    else if (clear) value <= '0;
    else if (load)  value <= load_value;
    else if (inc)   value <= bcd_up(value);
    else if (dec)   value <= bcd_down(value);
  end

  assign is_zero = (value == 24'h000000);

endmodule

// File: rtl/multi_timer_ctrl.sv
// N-channel BCD stopwatch/countdown engine: prescaler, command decode,
// per-channel run/mode/expiry flags, alarm hold counter and display mux.
module multi_timer_ctrl
  import timer_pkg::*;
#(
  parameter  int CLK_HZ       = 100_000_000,
  parameter  int N_CH         = 4,
  parameter  int ALARM_CYCLES = 100_000_000,
  localparam int CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk_100MHz,
  input  logic            reset,
  input  logic            cmd_valid,
  input  logic [2:0]      cmd_op,
  input  logic [CH_W-1:0] cmd_ch,
  input  logic [23:0]     load_value,
  output logic [CH_W-1:0] sel_ch,
  output logic [23:0]     disp_bcd,
  output logic            disp_running,
  output logic            disp_down,
  output logic [N_CH-1:0] running,
  output logic [N_CH-1:0] expired,
  output logic            alarm,
  output logic            cmd_err,
  output logic            o_1Hz
);

  localparam int PS_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [PS_W-1:0]    ps_cnt;
  logic               tick;
  logic [N_CH-1:0]    down;
  logic [N_CH-1:0]    hit, is_zero, is_one;
  logic [N_CH-1:0]    clr, ld, ss, md, inc, dec, expire;
  logic [23:0]        value [N_CH];
  logic [ALARM_W-1:0] alarm_cnt;
  logic               ch_ok, run_c, down_c, zero_c, cmd_bad, cmd_go;

  assign tick  = (ps_cnt == PS_W'(CLK_HZ - 1));
  assign o_1Hz = tick;

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset)    ps_cnt <= '0;
    else if (tick) ps_cnt <= '0;
    else           ps_cnt <= ps_cnt + PS_W'(1);
  end

  // Validation looks at the targeted channel's state before this edge.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      hit[i]    = (cmd_ch == CH_W'(i));
      is_one[i] = (value[i] == 24'h000001);
    end
    ch_ok  = |hit;
    run_c  = |(running & hit);
    down_c = |(down & hit);
    zero_c = |(is_zero & hit);
    cmd_bad = 1'b0;
    if (!ch_ok) cmd_bad = 1'b1;
    else begin
      case (cmd_op)
        OP_NOP, OP_CLEAR, OP_SELECT: cmd_bad = 1'b0;
        OP_START_STOP: cmd_bad = !run_c && down_c && zero_c;
        OP_MODE:       cmd_bad = run_c;
        OP_LOAD:       cmd_bad = !bcd_valid(load_value);
        default:       cmd_bad = 1'b1;
      endcase
    end
    cmd_go = cmd_valid && !cmd_bad;
  end

  // CLEAR/LOAD suppress the tick; a down step at zero is never issued.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      clr[i]    = cmd_go && hit[i] && (cmd_op == OP_CLEAR);
      ld[i]     = cmd_go && hit[i] && (cmd_op == OP_LOAD);
      ss[i]     = cmd_go && hit[i] && (cmd_op == OP_START_STOP);
      md[i]     = cmd_go && hit[i] && (cmd_op == OP_MODE);
      inc[i]    = tick && running[i] && !clr[i] && !ld[i] && !down[i];
      dec[i]    = tick && running[i] && !clr[i] && !ld[i] && down[i] && !is_zero[i];
      expire[i] = tick && running[i] && !clr[i] && !ld[i] && down[i] &&
                  (is_one[i] || is_zero[i]);
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    bcd_hms_counter u_cnt (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .inc        (inc[g]),
      .dec        (dec[g]),
      .clear      (clr[g]),
      .load       (ld[g]),
      .load_value (load_value),
      .value      (value[g]),
      .is_zero    (is_zero[g])
    );
  end

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      running   <= '0;
      down      <= '0;
      expired   <= '0;
      sel_ch    <= '0;
      cmd_err   <= 1'b0;
      alarm_cnt <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (clr[i] || expire[i]) running[i] <= 1'b0;
        else if (ss[i])          running[i] <= ~running[i];
        if (clr[i] || ld[i])     expired[i] <= 1'b0;
        else if (expire[i])      expired[i] <= 1'b1;
        if (md[i])               down[i]    <= ~down[i];
      end
      if (cmd_go && (cmd_op == OP_SELECT)) sel_ch <= cmd_ch;
      cmd_err <= cmd_valid && cmd_bad;
      if (|expire)                alarm_cnt <= ALARM_W'(ALARM_CYCLES);
      else if (alarm_cnt != '0)   alarm_cnt <= alarm_cnt - ALARM_W'(1);
    end
  end

  assign alarm = (alarm_cnt != '0);

  always_comb begin
    disp_bcd     = '0;
    disp_running = 1'b0;
    disp_down    = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel_ch == CH_W'(i)) begin
        disp_bcd     = value[i];
        disp_running = running[i];
        disp_down    = down[i];
      end
    end
  end

endmodule
